// File: rtl/spi_burst_ram_pkg.sv
// spi_ram_pkg: command codes and tx slot state encoding for the SPI burst RAM.
package spi_ram_pkg;
    localparam logic [1:0] CMD_SET_WR = 2'b00;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_SET_RD = 2'b10;
    localparam logic [1:0] CMD_READ   = 2'b11;
    typedef enum logic {TX_IDLE, TX_PEND} tx_state_e;
endpackage

// File: rtl/spi_burst_ram_if.sv
// spi_burst_ram_if: command stream in, read data handshake and error pulses out.
interface spi_burst_ram_if #(parameter int DATA_W = 8);
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              addr_err;
    logic              ovr_err;
    modport slave (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid, addr_err, ovr_err);
    modport master(output rx_data, rx_valid, tx_ready, input tx_data, tx_valid, addr_err, ovr_err);
endinterface

// File: rtl/spi_burst_ram_mem.sv
// spi_ram_mem: single write port, registered read port, no reset on the array.
module spi_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/spi_burst_ram.sv
// spi_burst_ram: decodes SPI command words into RAM writes/reads with burst pointers,
// a one-deep tx slot with back-pressure, and address/overrun error pulses.
module spi_burst_ram
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input logic            clk,
    input logic            rst,
    spi_burst_ram_if.slave bus
);
    tx_state_e         state;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              addr_err, ovr_err;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] p;
    logic              bad, slot_free, wr_go, rd_go, set_wr, set_rd, rd_cmd;

    function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a);
        return (32'(a) == MEM_DEPTH - 1) ? '0 : a + 1'b1;
    endfunction

    assign cmd       = bus.rx_data[DATA_W+1:DATA_W];
    assign p         = bus.rx_data[ADDR_W-1:0];
    assign bad       = 32'(p) >= MEM_DEPTH;
    assign slot_free = (state == TX_IDLE) || bus.tx_ready;
    assign set_wr    = bus.rx_valid && cmd == CMD_SET_WR;
    assign set_rd    = bus.rx_valid && cmd == CMD_SET_RD;
    assign wr_go     = bus.rx_valid && cmd == CMD_WRITE;
    assign rd_cmd    = bus.rx_valid && cmd == CMD_READ;
    assign rd_go     = rd_cmd && slot_free;

    spi_ram_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_mem (
        .clk    (clk),
        .wr_en  (wr_go),
        .wr_addr(wr_ptr),
        .wr_data(bus.rx_data[DATA_W-1:0]),
        .rd_en  (rd_go),
        .rd_addr(rd_ptr),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= TX_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            addr_err <= 1'b0;
            ovr_err  <= 1'b0;
        end else begin
            addr_err <= (set_wr || set_rd) && bad;
            ovr_err  <= rd_cmd && !slot_free;
            if (set_wr && !bad) wr_ptr <= p;
            else if (wr_go && AUTO_INC != 0) wr_ptr <= nxt(wr_ptr);
            if (set_rd && !bad) rd_ptr <= p;
            else if (rd_go && AUTO_INC != 0) rd_ptr <= nxt(rd_ptr);
            state <= rd_go ? TX_PEND : (bus.tx_ready ? TX_IDLE : state);
        end
    end

    // The read register holds its value while pending; masking gives the reset-time zero.
    assign bus.tx_valid = state == TX_PEND;
    assign bus.tx_data  = bus.tx_valid ? rd_data : '0;
    assign bus.addr_err = addr_err;
    assign bus.ovr_err  = ovr_err;
endmodule
